// File: rtl/mpbuffer_pkg.sv
// Shared definitions for the message-passing control protocol: flit field
// positions, control class and helpers used by initiators and endpoints.
package mpbuffer_pkg;

  typedef struct packed {
    int unsigned NOC_FLIT_WIDTH;
  } config_t;

  localparam config_t DEFAULT_CONFIG = '{NOC_FLIT_WIDTH: 32};

  localparam int DST_MSB      = 31;
  localparam int DST_LSB      = 27;
  localparam int CLASS_MSB    = 26;
  localparam int CLASS_LSB    = 24;
  localparam int SRC_MSB      = 23;
  localparam int SRC_LSB      = 19;
  localparam int TAG_MSB      = 18;
  localparam int TAG_LSB      = 2;
  localparam int ENABLED_BIT  = 1;
  localparam int RESPONSE_BIT = 0;

  localparam logic [2:0] CTRL_CLASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } query_state_t;

  function automatic logic [31:0] build_ctrl_req(input logic [4:0]  dst,
                                                 input logic [4:0]  src,
                                                 input logic [16:0] tag);
    logic [31:0] f;
    f = '0;
    f[DST_MSB:DST_LSB]     = dst;
    f[CLASS_MSB:CLASS_LSB] = CTRL_CLASS;
    f[SRC_MSB:SRC_LSB]     = src;
    f[TAG_MSB:TAG_LSB]     = tag;
    f[ENABLED_BIT]         = 1'b0;
    f[RESPONSE_BIT]        = 1'b0;
    return f;
  endfunction

  function automatic logic is_ctrl_resp(input logic [31:0] flit);
    return (flit[CLASS_MSB:CLASS_LSB] == CTRL_CLASS) && flit[RESPONSE_BIT];
  endfunction

endpackage

// File: rtl/mpbuffer_status_query.sv
// Bus-driven "is the remote endpoint enabled?" query initiator: sends one
// control request flit, waits for the tagged response or a timeout.
//
// state   | meaning
// IDLE    | no query outstanding, START accepted
// SEND    | request flit presented on noc_out until accepted
// WAIT    | request sent, waiting for matching response or timeout
module mpbuffer_status_query
  import mpbuffer_pkg::*;
#(
  parameter config_t CONFIG        = DEFAULT_CONFIG,
  parameter int      TILEID        = 0,
  parameter int      TIMEOUT_RESET = 1024,
  parameter int      TIMEOUT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [CONFIG.NOC_FLIT_WIDTH-1:0]  noc_out_flit,
  output logic                              noc_out_last,
  output logic                              noc_out_valid,
  input  logic                              noc_out_ready,
  input  logic [CONFIG.NOC_FLIT_WIDTH-1:0]  noc_in_flit,
  input  logic                              noc_in_last,
  input  logic                              noc_in_valid,
  output logic                              noc_in_ready,
  input  logic [31:0]                       bus_addr,
  input  logic                              bus_we,
  input  logic                              bus_en,
  input  logic [31:0]                       bus_data_in,
  output logic [31:0]                       bus_data_out,
  output logic                              bus_ack,
  output logic                              bus_err,
  output logic                              irq
);

  localparam int FW = CONFIG.NOC_FLIT_WIDTH;
  localparam int TW = TIMEOUT_WIDTH;

  query_state_t state, state_nxt;

  logic [4:0]    target;
  logic [7:0]    seq;
  logic [TW-1:0] timeout_reg;
  logic [TW-1:0] tmo_active;
  logic [TW-1:0] cnt;
  logic          done;
  logic          enabled;
  logic          timeout_flag;
  logic          stray;
  logic          draining;

  logic [31:0]   in_flit;
  logic [16:0]   cur_tag;
  logic [3:0]    reg_sel;
  logic          resp_match;
  logic          in_drop;
  logic          expire;
  logic          start_ok;
  logic          clear_we;
  logic          tmo_we;
  logic          unused_inputs;

  assign in_flit       = noc_in_flit[31:0];
  assign cur_tag       = {9'h0, seq};
  assign reg_sel       = bus_addr[5:2];
  assign noc_in_ready  = 1'b1;
  assign irq           = done;
  assign unused_inputs = ^{noc_in_flit, bus_addr, bus_data_in};

  assign noc_out_flit = FW'(build_ctrl_req(target, 5'(TILEID), cur_tag));

  // A flit that is part of a packet already being drained never matches.
  assign resp_match = noc_in_valid && !draining && (state == ST_WAIT) &&
                      is_ctrl_resp(in_flit) &&
                      (in_flit[SRC_MSB:SRC_LSB] == target) &&
                      (in_flit[TAG_MSB:TAG_LSB] == cur_tag);
  assign in_drop    = noc_in_valid && !resp_match;
  assign expire     = (state == ST_WAIT) && !resp_match &&
                      (tmo_active != '0) && (cnt == TW'(1));

  always_comb begin
    bus_ack      = 1'b0;
    bus_err      = 1'b0;
    bus_data_out = '0;
    start_ok     = 1'b0;
    clear_we     = 1'b0;
    tmo_we       = 1'b0;
    if (bus_en) begin
      case (reg_sel)
        4'h0: begin
          if (bus_we) begin
            if (state == ST_IDLE) begin
              bus_ack  = 1'b1;
              start_ok = 1'b1;
            end else begin
              bus_err = 1'b1;
            end
          end else begin
            bus_ack      = 1'b1;
            bus_data_out = {27'h0, stray, (state != ST_IDLE), timeout_flag,
                            enabled, done};
          end
        end
        4'h1: begin
          bus_ack = 1'b1;
          if (bus_we) clear_we = 1'b1;
          else        bus_data_out = {16'h0, seq, 3'h0, target};
        end
        4'h2: begin
          bus_ack = 1'b1;
          if (bus_we) tmo_we = 1'b1;
          else        bus_data_out = 32'(timeout_reg);
        end
        default: bus_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    noc_out_valid = 1'b0;
    noc_out_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        noc_out_valid = 1'b1;
        noc_out_last  = 1'b1;
        if (noc_out_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_match || expire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timeout is snapshotted at start so a write while busy only affects the next query.
  always_ff @(posedge clk) begin
    if (rst) begin
      target       <= '0;
      seq          <= '0;
      timeout_reg  <= TW'(TIMEOUT_RESET);
      tmo_active   <= TW'(TIMEOUT_RESET);
      cnt          <= '0;
      done         <= 1'b0;
      enabled      <= 1'b0;
      timeout_flag <= 1'b0;
      stray        <= 1'b0;
      draining     <= 1'b0;
    end else begin
      if (start_ok) begin
        target     <= bus_data_in[4:0];
        seq        <= seq + 8'd1;
        tmo_active <= timeout_reg;
      end
      if (tmo_we) timeout_reg <= bus_data_in[TW-1:0];

      if (state == ST_SEND && noc_out_ready) cnt <= tmo_active;
      else if (state == ST_WAIT)             cnt <= cnt - TW'(1);

      if (start_ok)                          done <= 1'b0;
      else if (resp_match || expire)         done <= 1'b1;
      else if (clear_we && bus_data_in[0])   done <= 1'b0;

      if (start_ok)        enabled <= 1'b0;
      else if (resp_match) enabled <= in_flit[ENABLED_BIT];
      else if (expire)     enabled <= 1'b0;

      if (start_ok)                          timeout_flag <= 1'b0;
      else if (expire)                       timeout_flag <= 1'b1;
      else if (clear_we && bus_data_in[2])   timeout_flag <= 1'b0;

      if (in_drop)                           stray <= 1'b1;
      else if (clear_we && bus_data_in[4])   stray <= 1'b0;

      // Stay in drain mode until the flit carrying last has been consumed.
      if (noc_in_valid) draining <= !noc_in_last;
    end
  end

endmodule

// File: tb/tb_mpbuffer_status_query.sv
// Scoreboard bench for mpbuffer_status_query: directed scenarios plus
// randomized queries checked against an event-level model of the block.
module tb_mpbuffer_status_query;
  import mpbuffer_pkg::*;

  localparam int TILE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] noc_out_flit;
  logic        noc_out_last, noc_out_valid, noc_out_ready;
  logic [31:0] noc_in_flit;
  logic        noc_in_last, noc_in_valid, noc_in_ready;
  logic [31:0] bus_addr, bus_data_in, bus_data_out;
  logic        bus_we, bus_en, bus_ack, bus_err, irq;

  always #5 clk = ~clk;

  mpbuffer_status_query #(.TILEID(TILE)) dut (
    .clk(clk), .rst(rst),
    .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
    .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_err(bus_err), .irq(irq)
  );

  typedef struct {
    bit          ack;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    bit          chk_irq;
    bit          irq;
    logic [31:0] addr;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_flit[$];
  int          checks = 0;
  int          errors = 0;

  // Event-level reference model
  logic [4:0]  m_target;
  logic [7:0]  m_seq;
  logic [15:0] m_timeout, m_tact;
  bit          m_done, m_en, m_tflag, m_stray, m_busy;

  function automatic logic [31:0] exp_status();
    return {27'h0, m_stray, m_busy, m_tflag, m_en, m_done};
  endfunction
  function automatic logic [31:0] exp_info();
    return {16'h0, m_seq, 3'h0, m_target};
  endfunction
  function automatic logic [31:0] req_flit(input logic [4:0] t, input logic [7:0] s);
    return {t, 3'b111, 5'(TILE), 9'h0, s, 2'b00};
  endfunction
  function automatic logic [31:0] resp_flit(input logic [4:0] t, input logic [7:0] s, input bit en);
    return {5'(TILE), 3'b111, t, 9'h0, s, en, 1'b1};
  endfunction

  task automatic m_reset();
    m_target = '0; m_seq = '0; m_timeout = 16'd1024; m_tact = 16'd1024;
    m_done = 0; m_en = 0; m_tflag = 0; m_stray = 0; m_busy = 0;
  endtask
  task automatic m_clear(input logic [31:0] d);
    if (d[0]) m_done = 0;
    if (d[2]) m_tflag = 0;
    if (d[4]) m_stray = 0;
  endtask
  task automatic m_resp(input bit en);
    m_done = 1; m_en = en; m_busy = 0;
  endtask
  task automatic m_expire();
    m_done = 1; m_tflag = 1; m_en = 0; m_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus_en = 0; bus_we = 0; noc_in_valid = 0; noc_in_last = 0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input bit exp_err);
    acc_t e;
    bus_en = 1; bus_we = 0; bus_addr = a;
    e.ack = !exp_err; e.err = exp_err; e.chk_data = !exp_err; e.data = exp;
    e.chk_irq = !exp_err && (a[5:2] == 4'h0); e.irq = exp[0]; e.addr = a;
    exp_acc.push_back(e);
    tick();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input bit exp_err, input bit do_tick);
    acc_t e;
    bus_en = 1; bus_we = 1; bus_addr = a; bus_data_in = d;
    e.ack = !exp_err; e.err = exp_err; e.chk_data = 0; e.data = '0;
    e.chk_irq = 0; e.irq = 0; e.addr = a;
    exp_acc.push_back(e);
    if (do_tick) tick();
  endtask

  task automatic send_flit(input logic [31:0] f, input bit last, input bit do_tick);
    noc_in_valid = 1; noc_in_flit = f; noc_in_last = last;
    if (do_tick) tick();
  endtask

  task automatic start_query(input logic [4:0] t);
    logic [31:0] d;
    d = $urandom; d[4:0] = t;
    m_seq = m_seq + 8'd1; m_target = t; m_done = 0; m_en = 0; m_tflag = 0;
    m_busy = 1; m_tact = m_timeout;
    exp_flit.push_back(req_flit(t, m_seq));
    bus_wr(32'h0, d, 0, 1);
  endtask

  task automatic set_timeout(input logic [15:0] v);
    bus_wr(32'h8, {$urandom_range(0, 65535), v} >> 16 << 16 | 32'(v), 0, 1);
    m_timeout = v;
  endtask

  // Returns at the start of the first WAIT cycle.
  task automatic wait_accept();
    bit hs;
    hs = 0;
    for (int i = 0; i < 64 && !hs; i++) begin
      noc_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hs = noc_out_valid && noc_out_ready;
      @(posedge clk); #1;
    end
    noc_out_ready = 0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL accept_timeout: request not accepted within 64 cycles, required handshake");
    end
  endtask

  task automatic inject_strays(input int n);
    int left;
    int k;
    logic [31:0] f0;
    logic [7:0] bad_seq;
    left = n;
    while (left > 0) begin
      case ($urandom_range(0, 2))
        0: begin
          bad_seq = m_seq + 8'd1;
          send_flit(resp_flit(m_target, bad_seq, 1'($urandom_range(0, 1))), 1, 1);
          left--;
        end
        1: begin
          send_flit(resp_flit(m_target ^ 5'd1, m_seq, 1), 1, 1);
          left--;
        end
        default: begin
          k = $urandom_range(1, (left > 3) ? 3 : left);
          f0 = $urandom;
          f0[26:24] = 3'($urandom_range(0, 6));
          for (int i = 0; i < k; i++)
            send_flit((i == 0) ? f0 : resp_flit(m_target, m_seq, 1), (i == k - 1), 1);
          left -= k;
        end
      endcase
      m_stray = 1;
    end
  endtask

  initial begin
    rst = 1; noc_out_ready = 0; noc_in_valid = 0; noc_in_last = 0; noc_in_flit = '0;
    bus_en = 0; bus_we = 0; bus_addr = '0; bus_data_in = '0;
    m_reset();
    fork
      begin : monitor
        acc_t e;
        logic [31:0] ef;
        forever begin
          @(negedge clk);
          if (bus_en) begin
            checks++;
            if (exp_acc.size() == 0) begin
              errors++;
              $display("FAIL bus_unexpected: access at addr %h with nothing expected", bus_addr);
            end else begin
              e = exp_acc.pop_front();
              if (bus_ack !== e.ack || bus_err !== e.err) begin
                errors++;
                $display("FAIL bus_resp addr %h: ack/err got %b/%b, expected %b/%b",
                         e.addr, bus_ack, bus_err, e.ack, e.err);
              end
              if (e.chk_data) begin
                checks++;
                if (bus_data_out !== e.data) begin
                  errors++;
                  $display("FAIL bus_read addr %h: got %h, expected %h", e.addr, bus_data_out, e.data);
                end
              end
              if (e.chk_irq) begin
                checks++;
                if (irq !== e.irq) begin
                  errors++;
                  $display("FAIL irq: got %b, expected %b", irq, e.irq);
                end
              end
            end
          end else begin
            checks++;
            if (bus_ack !== 1'b0 || bus_err !== 1'b0 || noc_in_ready !== 1'b1) begin
              errors++;
              $display("FAIL idle_outputs: ack/err/in_ready got %b/%b/%b, expected 0/0/1",
                       bus_ack, bus_err, noc_in_ready);
            end
          end
          if (noc_out_valid && noc_out_ready) begin
            checks++;
            if (exp_flit.size() == 0) begin
              errors++;
              $display("FAIL req_unexpected: flit %h sent with none expected", noc_out_flit);
            end else begin
              ef = exp_flit.pop_front();
              if (noc_out_flit !== ef || noc_out_last !== 1'b1) begin
                errors++;
                $display("FAIL req_flit: got %h last %b, expected %h last 1", noc_out_flit, noc_out_last, ef);
              end
            end
          end
        end
      end
      begin : stimulus
        logic [4:0]  t;
        logic [31:0] d;
        int          tt, j, s;
        bit          en;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (noc_out_valid !== 1'b0 || irq !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs: valid/irq got %b/%b, expected 0/0", noc_out_valid, irq);
        end
        @(posedge clk); #1;

        // Reset values and address decode
        bus_rd(32'h0, exp_status(), 0);
        bus_rd(32'h4, exp_info(), 0);
        bus_rd(32'h8, 32'd1024, 0);
        bus_rd(32'hC, 32'h0, 1);
        bus_wr(32'h3C, 32'hFFFF_FFFF, 1, 1);
        bus_rd(32'h40, exp_status(), 0);

        // Basic enabled query to tile 5
        start_query(5'd5);
        wait_accept();
        bus_rd(32'h0, exp_status(), 0);
        send_flit(resp_flit(5'd5, m_seq, 1), 1, 1);
        m_resp(1);
        bus_rd(32'h0, exp_status(), 0);
        bus_rd(32'h4, exp_info(), 0);

        // Timeout of 10 cycles, then a late response
        set_timeout(16'd10);
        bus_rd(32'h8, 32'd10, 0);
        start_query(5'd9);
        wait_accept();
        bus_rd(32'h0, exp_status(), 0);
        repeat (8) tick();
        bus_rd(32'h0, exp_status(), 0);
        m_expire();
        bus_rd(32'h0, exp_status(), 0);
        send_flit(resp_flit(5'd9, m_seq, 1), 1, 1);
        m_stray = 1;
        bus_rd(32'h0, exp_status(), 0);
        bus_wr(32'h4, 32'h15, 0, 1);
        m_clear(32'h15);
        bus_rd(32'h0, exp_status(), 0);

        // Busy START, wrong tag, multi-flit foreign packet, then the real response
        start_query(5'd7);
        bus_wr(32'h0, 32'h1F, 1, 1);
        wait_accept();
        bus_wr(32'h0, 32'h3, 1, 1);
        begin
          logic [7:0] bs;
          bs = m_seq + 8'd1;
          send_flit(resp_flit(5'd7, bs, 1), 1, 1);
        end
        d = $urandom; d[26:24] = 3'b011;
        send_flit(d, 0, 1);
        send_flit(resp_flit(5'd7, m_seq, 1), 0, 1);
        send_flit(resp_flit(5'd7, m_seq, 1), 1, 1);
        m_stray = 1;
        bus_rd(32'h0, exp_status(), 0);
        bus_rd(32'h4, exp_info(), 0);
        send_flit(resp_flit(5'd7, m_seq, 0), 1, 1);
        m_resp(0);
        bus_rd(32'h0, exp_status(), 0);

        // Response in the same cycle as expiry
        bus_wr(32'h4, 32'h15, 0, 1); m_clear(32'h15);
        set_timeout(16'd4);
        start_query(5'd3);
        wait_accept();
        bus_rd(32'h0, exp_status(), 0);
        tick(); tick();
        send_flit(resp_flit(5'd3, m_seq, 1), 1, 1);
        m_resp(1);
        bus_rd(32'h0, exp_status(), 0);

        // Timeout of zero waits indefinitely
        set_timeout(16'd0);
        start_query(5'd12);
        wait_accept();
        bus_rd(32'h0, exp_status(), 0);
        repeat (40) tick();
        bus_rd(32'h0, exp_status(), 0);
        send_flit(resp_flit(5'd12, m_seq, 0), 1, 1);
        m_resp(0);
        bus_rd(32'h0, exp_status(), 0);

        // Clear of done in the same cycle as the response
        set_timeout(16'd6);
        start_query(5'd20);
        wait_accept();
        bus_rd(32'h0, exp_status(), 0);
        send_flit(resp_flit(5'd20, m_seq, 1), 1, 0);
        bus_wr(32'h4, 32'h15, 0, 1);
        m_clear(32'h15); m_resp(1);
        bus_rd(32'h0, exp_status(), 0);

        // TIMEOUT write while busy applies only to the next query
        start_query(5'd1);
        wait_accept();
        bus_wr(32'h8, 32'd3, 0, 1); m_timeout = 16'd3;
        repeat (4) tick();
        bus_rd(32'h0, exp_status(), 0);
        m_expire();
        bus_rd(32'h0, exp_status(), 0);
        bus_rd(32'h8, 32'd3, 0);

        // Reset with a query in flight; the old response is then stray
        start_query(5'd4);
        wait_accept();
        d = resp_flit(5'd4, m_seq, 1);
        rst = 1; tick(); rst = 0;
        m_reset();
        send_flit(d, 1, 1);
        m_stray = 1;
        bus_rd(32'h0, exp_status(), 0);
        bus_rd(32'h4, exp_info(), 0);
        bus_rd(32'h8, 32'd1024, 0);

        // Randomized queries; enough to wrap seq
        set_timeout(16'd8);
        for (int q = 0; q < 280; q++) begin
          if ($urandom_range(0, 1) != 0) set_timeout(16'($urandom_range(2, 20)));
          t = 5'($urandom_range(0, 31));
          start_query(t);
          tt = int'(m_tact);
          if ($urandom_range(0, 1) != 0) bus_wr(32'h0, $urandom, 1, 1);
          wait_accept();
          case ($urandom_range(0, 2))
            0: bus_rd(32'h0, exp_status(), 0);
            1: bus_wr(32'h0, $urandom, 1, 1);
            default: begin
              logic [15:0] nv;
              nv = 16'($urandom_range(2, 20));
              bus_wr(32'h8, 32'(nv), 0, 1);
              m_timeout = nv;
            end
          endcase
          if ($urandom_range(0, 3) != 0) begin
            j = $urandom_range(2, tt);
            s = $urandom_range(0, j - 2);
            inject_strays(s);
            repeat (j - 2 - s) tick();
            en = 1'($urandom_range(0, 1));
            send_flit(resp_flit(t, m_seq, en), 1, 1);
            m_resp(en);
          end else begin
            s = $urandom_range(0, tt - 1);
            inject_strays(s);
            repeat (tt - 1 - s) tick();
            m_expire();
            if ($urandom_range(0, 1) != 0) begin
              send_flit(resp_flit(t, m_seq, 1), 1, 1);
              m_stray = 1;
            end
          end
          bus_rd(32'h0, exp_status(), 0);
          if ($urandom_range(0, 1) != 0) bus_rd(32'h4, exp_info(), 0);
          if ($urandom_range(0, 2) == 0) begin
            d = $urandom;
            bus_wr(32'h4, d, 0, 1);
            m_clear(d);
          end
          if ($urandom_range(0, 4) == 0) bus_rd(32'h8, {16'h0, m_timeout}, 0);
        end

        bus_rd(32'h4, exp_info(), 0);
        bus_wr(32'h4, 32'h15, 0, 1);
        m_clear(32'h15);
        bus_rd(32'h0, exp_status(), 0);
        repeat (2) tick();

        checks++;
        if (exp_acc.size() != 0 || exp_flit.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain: %0d bus and %0d flit entries left, expected 0/0",
                   exp_acc.size(), exp_flit.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
